frag_loader: RTL and testbench

Front-end sequencer for the fragment memory. It takes a byte stream, packs each byte into a sequential byte-addressed write (fragment index plus byte offset), and loads a run of 256-byte fragments starting at a programmable base. Between loads it arbitrates single-fragment read requests from the downstream consumer and reports when the fragment memory's wide read data is valid. It sits directly upstream of the fragment memory and drives all of its request/address/data inputs.

---
 rtl/frag_pkg.sv | 21 ++
 rtl/frag_addr_gen.sv | 42 ++++
 rtl/frag_loader.sv | 122 ++++++++++++
 tb/tb_frag_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frag_pkg.sv
// Shared types and constants for the fragment-memory loader.
// Address layout is {1'b0, fragment[6:0], byte[7:0]}.
package frag_pkg;
  localparam int AW         = 16;
  localparam int BYTE       = 8;
  localparam int FRAG_IDX_W = 7;
  localparam int BYTE_IDX_W = 8;
  localparam int FRAG_BYTES = 256;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;

  function automatic logic [AW-1:0] frag_addr(input logic [FRAG_IDX_W-1:0] frag,
                                              input logic [BYTE_IDX_W-1:0] byte_idx);
    return {1'b0, frag, byte_idx};
  endfunction
endpackage

// File: rtl/frag_addr_gen.sv
// Byte/fragment counters for a load session: base-relative fragment index
// with 7-bit wrap, and a flag marking the final byte of the session.
module frag_addr_gen
  import frag_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_clr,
  input  logic                  i_adv,
  input  logic [FRAG_IDX_W-1:0] i_base,
  input  logic [7:0]            i_num,
  output logic [FRAG_IDX_W-1:0] o_frag,
  output logic [BYTE_IDX_W-1:0] o_byte,
  output logic                  o_last
);
  logic [FRAG_IDX_W-1:0] r_base;
  logic [7:0]            r_num;
  logic [7:0]            r_frag_cnt;
  logic [BYTE_IDX_W-1:0] r_byte_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base     <= '0;
      r_num      <= '0;
      r_frag_cnt <= '0;
      r_byte_cnt <= '0;
    end else if (i_clr) begin
      r_base     <= i_base;
      r_num      <= i_num;
      r_frag_cnt <= '0;
      r_byte_cnt <= '0;
    end else if (i_adv) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
      if (r_byte_cnt == '1) r_frag_cnt <= r_frag_cnt + 1'b1;
    end
  end

  // 7-bit sum wraps fragment 127 -> 0 naturally
  assign o_frag = r_base + r_frag_cnt[FRAG_IDX_W-1:0];
  assign o_byte = r_byte_cnt;
  assign o_last = (r_byte_cnt == '1) && (r_frag_cnt == r_num - 8'd1);
endmodule

// File: rtl/frag_loader.sv
// Fragment-memory front end: streams bytes into sequential writes across a
// run of fragments, and serves single-fragment read requests between loads.
module frag_loader
  import frag_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [FRAG_IDX_W-1:0] base_frag,
  input  logic [7:0]            num_frags,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [BYTE-1:0]       s_data,
  output logic                  s_ready,
  input  logic                  rd_req,
  input  logic [FRAG_IDX_W-1:0] rd_frag,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_wnr,
  output logic [AW-1:0]         mem_addr,
  output logic [BYTE-1:0]       mem_data,
  input  logic                  mem_ready
);
  state_t                r_state, w_state_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_wnr, w_mem_wnr_nxt;
  logic [AW-1:0]         r_mem_addr, w_mem_addr_nxt;
  logic [BYTE-1:0]       r_mem_data, w_mem_data_nxt;
  logic                  w_clr, w_adv, w_last;
  logic [FRAG_IDX_W-1:0] w_frag;
  logic [BYTE_IDX_W-1:0] w_byte;

  frag_addr_gen u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr),
    .i_adv  (w_adv),
    .i_base (base_frag),
    .i_num  (num_frags),
    .o_frag (w_frag),
    .o_byte (w_byte),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_wnr  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_wnr  <= w_mem_wnr_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_data <= w_mem_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_done_nxt     = 1'b0;
    w_mem_req_nxt  = 1'b0;
    w_mem_wnr_nxt  = r_mem_wnr;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_clr          = 1'b0;
    w_adv          = 1'b0;
    case (r_state)
      S_IDLE: begin
        // start outranks rd_req; an empty session just reports done
        if (start) begin
          if (num_frags != 8'd0) begin
            w_clr       = 1'b1;
            w_state_nxt = S_LOAD;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else if (rd_req) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_wnr_nxt  = 1'b0;
          w_mem_addr_nxt = frag_addr(rd_frag, '0);
          w_state_nxt    = S_RD_WAIT;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          w_adv          = 1'b1;
          w_mem_req_nxt  = 1'b1;
          w_mem_wnr_nxt  = 1'b1;
          w_mem_data_nxt = s_data;
          w_mem_addr_nxt = frag_addr(w_frag, w_byte);
        end
        // a write accepted alongside abort still goes out, but done does not
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (s_valid && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_RD_WAIT: if (mem_ready) w_state_nxt = S_RD_DONE;
      S_RD_DONE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign s_ready  = (r_state == S_LOAD);
  assign rd_valid = (r_state == S_RD_DONE);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign mem_req  = r_mem_req;
  assign mem_wnr  = r_mem_wnr;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
endmodule

// File: tb/tb_frag_loader.sv
// Scoreboard bench for frag_loader: the driver queues each expected memory
// access as it issues stimulus, and a negedge monitor pops and compares.
module tb_frag_loader;
  import frag_pkg::*;

  logic clk = 1'b0, rstn = 1'b0;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0, rd_req = 1'b0, mem_ready;
  logic [6:0] base_frag = '0, rd_frag = '0;
  logic [7:0] num_frags = '0, s_data = '0;
  logic s_ready, rd_valid, busy, done, mem_req, mem_wnr;
  logic [15:0] mem_addr;
  logic [7:0] mem_data;

  typedef struct packed {
    logic        rd;
    logic        last;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0, done_cnt = 0, rdv_cnt = 0;
  bit allow_bare_done = 1'b0;

  always #5 clk = ~clk;

  frag_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .base_frag(base_frag),
    .num_frags(num_frags), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .rd_req(rd_req), .rd_frag(rd_frag), .rd_valid(rd_valid),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_wnr(mem_wnr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready)
  );

  // memory: read-ready one cycle after a read request
  always @(posedge clk or negedge rstn)
    if (!rstn) mem_ready <= 1'b0;
    else       mem_ready <= mem_req && !mem_wnr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h expected none", nm, act);
  endtask

  always @(negedge clk) if (rstn) begin
    if (done)     done_cnt++;
    if (rd_valid) rdv_cnt++;
    if (mem_req) begin
      if (exp_q.size() == 0) fail("mem_unexpected", {mem_wnr, mem_addr});
      else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.rd) begin
          check("rd_access", {mem_wnr, mem_addr}, {1'b0, e.addr});
        end else begin
          check("wr_access", {mem_wnr, mem_addr, mem_data}, {1'b1, e.addr, e.data});
          check("done_align", done, e.last);
        end
      end
    end else if (done) begin
      check("bare_done", allow_bare_done, 1'b1);
    end
  end

  task automatic do_start(input logic [6:0] b, input logic [7:0] n);
    start = 1'b1; base_frag = b; num_frags = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends n bytes (data = index ^ xr); called and returns at a negedge.
  task automatic send(input int n, input logic [6:0] base, input logic [7:0] xr,
                      input bit gaps, input int last_idx);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int tries;
      exp_t e;
      logic [7:0] kb;
      acc = 1'b0; tries = 0; kb = k[7:0];
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      while (!acc) begin
        s_valid = 1'b1; s_data = kb ^ xr;
        acc = s_ready;
        if (acc) begin
          e.rd = 1'b0; e.last = (k == last_idx);
          e.addr = {1'b0, base + 7'(k / 256), kb};
          e.data = kb ^ xr;
          exp_q.push_back(e);
        end
        @(negedge clk);
        if (++tries > 100) begin
          fail("s_ready_timeout", k);
          s_valid = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic push_rd(input logic [6:0] f);
    exp_t e;
    e.rd = 1'b1; e.last = 1'b0; e.addr = {1'b0, f, 8'h00}; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] v_req, v_rdv, v_busy;
    bit seen;
    // reset with inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = i[0]; s_valid = ~i[0]; rd_req = i[1]; abort = i[0]; num_frags = 8'd3;
    end
    check("reset_outs", {s_ready, rd_valid, busy, done, mem_req, mem_wnr, mem_addr, mem_data}, 0);
    start = 0; s_valid = 0; rd_req = 0; abort = 0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    check("post_reset_outs", {s_ready, rd_valid, busy, done, mem_req, mem_wnr, mem_addr, mem_data}, 0);

    // single fragment at base 3, back-to-back
    do_start(7'd3, 8'd1);
    check("load_busy", {busy, s_ready}, 2'b11);
    send(256, 7'd3, 8'h00, 1'b0, 255);
    check("load1_sready_drop", s_ready, 1'b0);
    idle(3);
    check("load1_done_cnt", done_cnt, 1);
    check("load1_drained", exp_q.size(), 0);

    // two fragments wrapping 127 -> 0, with gaps
    do_start(7'd127, 8'd2);
    send(512, 7'd127, 8'hA5, 1'b1, 511);
    idle(3);
    check("load2_done_cnt", done_cnt, 2);
    check("load2_drained", exp_q.size(), 0);

    // abort after 10 bytes; 11th byte rides the abort edge
    do_start(7'd10, 8'd2);
    send(10, 7'd10, 8'h00, 1'b0, -1);
    begin
      exp_t e;
      s_valid = 1'b1; abort = 1'b1; s_data = 8'd10;
      e.rd = 1'b0; e.last = 1'b0; e.addr = 16'h0A0A; e.data = 8'd10;
      exp_q.push_back(e);
      @(negedge clk);
      s_valid = 1'b0; abort = 1'b0;
    end
    check("abort_busy", busy, 1'b0);
    idle(4);
    check("abort_no_done", done_cnt, 2);
    check("abort_drained", exp_q.size(), 0);
    do_start(7'd10, 8'd1);
    send(256, 7'd10, 8'h3C, 1'b0, 255);
    idle(3);
    check("reload_done_cnt", done_cnt, 3);

    // read with request held past RD_DONE
    rd_req = 1'b1; rd_frag = 7'd5;
    push_rd(7'd5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 3) push_rd(7'd5);
      v_req[c] = mem_req; v_rdv[c] = rd_valid; v_busy[c] = busy;
    end
    rd_req = 1'b0;
    check("rd_mem_req_seq", v_req, 5'b10001);
    check("rd_valid_seq", v_rdv, 5'b00100);
    check("rd_busy_seq", v_busy, 5'b10111);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = !busy;
    end
    if (!seen) fail("rd_finish_timeout", busy);
    idle(2);
    check("rd_valid_cnt", rdv_cnt, 2);

    // start and rd_req together: load first, read after done
    rd_req = 1'b1; rd_frag = 7'd9;
    do_start(7'd20, 8'd1);
    send(256, 7'd20, 8'h5A, 1'b0, 255);
    push_rd(7'd9);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rd_valid;
    end
    if (!seen) fail("rd_after_load_timeout", rd_valid);
    rd_req = 1'b0;
    idle(3);
    check("combo_done_cnt", done_cnt, 4);
    check("combo_rdv_cnt", rdv_cnt, 3);

    // empty session
    allow_bare_done = 1'b1;
    do_start(7'd1, 8'd0);
    check("zero_done", {done, busy, mem_req}, 3'b100);
    @(negedge clk);
    check("zero_done_pulse", done, 1'b0);
    allow_bare_done = 1'b0;
    idle(3);
    check("zero_done_cnt", done_cnt, 5);
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
